// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state codes, credit width and price table for the vending controller
package vending_pkg;

    localparam int CREDIT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE            = 3'b000,
        ST_WAIT_COIN       = 3'b001,
        ST_SELECT_PRODUCT  = 3'b010,
        ST_DISPENSE_CHANGE = 3'b011,
        ST_RETURN_MONEY    = 3'b100
    } vm_state_e;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] sel);
        logic [CREDIT_W-1:0] p;
        case (sel)
            2'd0:    p = 8'd15;
            2'd1:    p = 8'd20;
            2'd2:    p = 8'd25;
            default: p = 8'd30;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vm_cycle_timer.sv
// rtl/vm_cycle_timer.sv - loadable down-counter shared by the inactivity timeout and dispense hold
module vm_cycle_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         enable_i,
    output logic         expire_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == '0);

endmodule

// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - coin-credit vending FSM with dispense hold, change, refund and timeout
module vending_controller
    import vending_pkg::*;
#(
    parameter logic [2:0] pIDLE            = 3'b000,
    parameter logic [2:0] pWAIT_COIN       = 3'b001,
    parameter logic [2:0] pSELECT_PRODUCT  = 3'b010,
    parameter logic [2:0] pDISPENSE_CHANGE = 3'b011,
    parameter logic [2:0] pRETURN_MONEY    = 3'b100,
    parameter int         DISPENSE_CYCLES  = 4,
    parameter int         TIMEOUT_CYCLES   = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                product_sel_valid,
    input  logic [1:0]          product_sel,
    input  logic                cancel,
    output logic [2:0]          state_out,
    output logic                display_status_en,
    output logic                product_dispense_done,
    output logic                change_dispense_done,
    output logic                dispense_product,
    output logic [1:0]          product_id,
    output logic [CREDIT_W-1:0] balance,
    output logic [CREDIT_W-1:0] change_amount,
    output logic [CREDIT_W-1:0] return_amount,
    output logic                coin_reject
);

    localparam int TMR_MAX = (TIMEOUT_CYCLES > DISPENSE_CYCLES) ? TIMEOUT_CYCLES : DISPENSE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    // Loaded with N-1 so that expiry is seen in the Nth cycle of the interval.
    localparam logic [TMR_W-1:0] TMR_TIMEOUT  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_DISPENSE = TMR_W'(DISPENSE_CYCLES - 1);

    vm_state_e           state_q, state_d;
    logic [2:0]          state_out_q, state_code_d;
    logic [CREDIT_W-1:0] balance_q, balance_d;
    logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
    logic [CREDIT_W-1:0] return_amount_q, return_amount_d;
    logic [CREDIT_W-1:0] remain;
    logic [1:0]          product_id_q, product_id_d;
    logic                disp_q, disp_d;
    logic                prod_done_q, prod_done_d;
    logic                chg_done_q, chg_done_d;
    logic                reject_q, reject_d;
    logic                display_q, display_d;
    logic [CREDIT_W:0]   coin_sum;
    logic                tmr_load, tmr_en, tmr_expire;
    logic [TMR_W-1:0]    tmr_value;

    vm_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (tmr_load),
        .value_i  (tmr_value),
        .enable_i (tmr_en),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d         = state_q;
        balance_d       = balance_q;
        product_id_d    = product_id_q;
        change_amount_d = '0;
        return_amount_d = '0;
        disp_d          = 1'b0;
        prod_done_d     = 1'b0;
        chg_done_d      = 1'b0;
        reject_d        = 1'b0;
        tmr_load        = 1'b0;
        tmr_en          = 1'b0;
        tmr_value       = TMR_TIMEOUT;
        remain          = balance_q - price_of(product_id_q);
        coin_sum        = {1'b0, balance_q} + {1'b0, coin_value};

        case (state_q)
            ST_IDLE: begin
                if (coin_valid) begin
                    balance_d = coin_value;
                    state_d   = ST_WAIT_COIN;
                    tmr_load  = 1'b1;
                end
            end
            ST_WAIT_COIN: begin
                if (cancel) begin
                    state_d         = ST_RETURN_MONEY;
                    return_amount_d = balance_q;
                    reject_d        = coin_valid;
                end else if (product_sel_valid && (balance_q >= price_of(product_sel))) begin
                    product_id_d = product_sel;
                    state_d      = ST_SELECT_PRODUCT;
                    disp_d       = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_value    = TMR_DISPENSE;
                    reject_d     = coin_valid;
                end else if (coin_valid || product_sel_valid) begin
                    // An unaffordable selection still counts as user activity.
                    tmr_load = 1'b1;
                    if (coin_valid) begin
                        if (coin_sum[CREDIT_W]) begin
                            reject_d = 1'b1;
                        end else begin
                            balance_d = coin_sum[CREDIT_W-1:0];
                        end
                    end
                end else if (tmr_expire) begin
                    state_d         = ST_RETURN_MONEY;
                    return_amount_d = balance_q;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SELECT_PRODUCT: begin
                reject_d = coin_valid;
                if (tmr_expire) begin
                    prod_done_d = 1'b1;
                    balance_d   = remain;
                    state_d     = (remain != '0) ? ST_DISPENSE_CHANGE : ST_IDLE;
                end else begin
                    disp_d = 1'b1;
                    tmr_en = 1'b1;
                end
            end
            ST_DISPENSE_CHANGE: begin
                reject_d        = coin_valid;
                change_amount_d = balance_q;
                chg_done_d      = 1'b1;
                balance_d       = '0;
                state_d         = ST_IDLE;
            end
            ST_RETURN_MONEY: begin
                reject_d  = coin_valid;
                balance_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                balance_d = '0;
            end
        endcase
    end

    always_comb begin
        case (state_d)
            ST_WAIT_COIN:       state_code_d = pWAIT_COIN;
            ST_SELECT_PRODUCT:  state_code_d = pSELECT_PRODUCT;
            ST_DISPENSE_CHANGE: state_code_d = pDISPENSE_CHANGE;
            ST_RETURN_MONEY:    state_code_d = pRETURN_MONEY;
            default:            state_code_d = pIDLE;
        endcase
        display_d = (state_code_d != state_out_q) || prod_done_d || chg_done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            state_out_q     <= pIDLE;
            balance_q       <= '0;
            product_id_q    <= '0;
            change_amount_q <= '0;
            return_amount_q <= '0;
            disp_q          <= 1'b0;
            prod_done_q     <= 1'b0;
            chg_done_q      <= 1'b0;
            reject_q        <= 1'b0;
            display_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            state_out_q     <= state_code_d;
            balance_q       <= balance_d;
            product_id_q    <= product_id_d;
            change_amount_q <= change_amount_d;
            return_amount_q <= return_amount_d;
            disp_q          <= disp_d;
            prod_done_q     <= prod_done_d;
            chg_done_q      <= chg_done_d;
            reject_q        <= reject_d;
            display_q       <= display_d;
        end
    end

    assign state_out             = state_out_q;
    assign display_status_en     = display_q;
    assign product_dispense_done = prod_done_q;
    assign change_dispense_done  = chg_done_q;
    assign dispense_product      = disp_q;
    assign product_id            = product_id_q;
    assign balance               = balance_q;
    assign change_amount         = change_amount_q;
    assign return_amount         = return_amount_q;
    assign coin_reject           = reject_q;

endmodule

// File: tb/tb_vending_controller.sv
// tb/tb_vending_controller.sv - directed self-checking bench for vending_controller
module tb_vending_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [7:0] coin_value = 8'd0;
    logic       product_sel_valid = 1'b0;
    logic [1:0] product_sel = 2'd0;
    logic       cancel = 1'b0;
    logic [2:0] state_out;
    logic       display_status_en;
    logic       product_dispense_done;
    logic       change_dispense_done;
    logic       dispense_product;
    logic [1:0] product_id;
    logic [7:0] balance;
    logic [7:0] change_amount;
    logic [7:0] return_amount;
    logic       coin_reject;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vending_controller dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .coin_valid            (coin_valid),
        .coin_value            (coin_value),
        .product_sel_valid     (product_sel_valid),
        .product_sel           (product_sel),
        .cancel                (cancel),
        .state_out             (state_out),
        .display_status_en     (display_status_en),
        .product_dispense_done (product_dispense_done),
        .change_dispense_done  (change_dispense_done),
        .dispense_product      (dispense_product),
        .product_id            (product_id),
        .balance               (balance),
        .change_amount         (change_amount),
        .return_amount         (return_amount),
        .coin_reject           (coin_reject)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        coin_valid = 1'b0;
        coin_value = 8'd0;
        product_sel_valid = 1'b0;
        product_sel = 2'd0;
        cancel = 1'b0;
    endtask

    task automatic coin(input logic [7:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        idle_inputs();
    endtask

    task automatic sel(input logic [1:0] s);
        product_sel_valid = 1'b1;
        product_sel = s;
        tick();
        idle_inputs();
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_state", state_out, 0);
        chk("rst_balance", balance, 0);
        chk("rst_dispense", dispense_product, 0);
        chk("rst_display", display_status_en, 0);
        chk("rst_pid", product_id, 0);
        chk("rst_ret", return_amount, 0);
        rst_n = 1'b1;
        tick();

        // 10 + 10, select product 1 (20): exact payment
        coin(8'd10);
        chk("a_state_wait", state_out, 1);
        chk("a_bal10", balance, 10);
        chk("a_disp_en", display_status_en, 1);
        coin(8'd10);
        chk("a_bal20", balance, 20);
        chk("a_disp_en_quiet", display_status_en, 0);
        sel(2'd1);
        chk("a_state_sel", state_out, 2);
        chk("a_pid", product_id, 1);
        chk("a_motor_c1", dispense_product, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a_motor_hold", dispense_product, 1);
            chk("a_no_done_yet", product_dispense_done, 0);
        end
        tick();
        chk("a_motor_off", dispense_product, 0);
        chk("a_done", product_dispense_done, 1);
        chk("a_state_idle", state_out, 0);
        chk("a_bal0", balance, 0);
        chk("a_done_disp_en", display_status_en, 1);
        tick();
        chk("a_done_pulse", product_dispense_done, 0);

        // 25, select product 0 (15): change 10
        coin(8'd25);
        chk("b_bal25", balance, 25);
        sel(2'd0);
        chk("b_state_sel", state_out, 2);
        repeat (3) tick();
        tick();
        chk("b_done", product_dispense_done, 1);
        chk("b_state_chg", state_out, 3);
        chk("b_bal10", balance, 10);
        tick();
        chk("b_chg_done", change_dispense_done, 1);
        chk("b_chg_amt", change_amount, 10);
        chk("b_state_idle", state_out, 0);
        chk("b_bal0", balance, 0);
        chk("b_done_clr", product_dispense_done, 0);
        tick();
        chk("b_chg_pulse", change_dispense_done, 0);

        // 10, select product 3 (30): ignored, then cancel
        coin(8'd10);
        sel(2'd3);
        chk("c_state_wait", state_out, 1);
        chk("c_bal10", balance, 10);
        chk("c_no_motor", dispense_product, 0);
        cancel = 1'b1;
        tick();
        idle_inputs();
        chk("c_state_ret", state_out, 4);
        chk("c_ret10", return_amount, 10);
        tick();
        chk("c_state_idle", state_out, 0);
        chk("c_bal0", balance, 0);

        // 200 + 100 overflows, cancel refunds 200
        coin(8'd200);
        coin(8'd100);
        chk("d_reject", coin_reject, 1);
        chk("d_bal200", balance, 200);
        tick();
        chk("d_reject_pulse", coin_reject, 0);
        cancel = 1'b1;
        tick();
        idle_inputs();
        chk("d_state_ret", state_out, 4);
        chk("d_ret200", return_amount, 200);
        chk("d_ret_disp_en", display_status_en, 1);
        tick();
        chk("d_state_idle", state_out, 0);
        chk("d_ret_clr", return_amount, 0);
        chk("d_bal0", balance, 0);

        // selection beats a same-cycle coin, coin is refused
        coin(8'd20);
        product_sel_valid = 1'b1;
        product_sel = 2'd1;
        coin_valid = 1'b1;
        coin_value = 8'd5;
        tick();
        idle_inputs();
        chk("e_state_sel", state_out, 2);
        chk("e_reject", coin_reject, 1);
        chk("e_bal20", balance, 20);
        repeat (3) tick();
        tick();
        chk("e_done", product_dispense_done, 1);
        chk("e_state_idle", state_out, 0);

        // inactivity timeout after exactly 1000 idle cycles
        coin(8'd5);
        chk("f_state_wait", state_out, 1);
        repeat (999) tick();
        chk("f_still_wait", state_out, 1);
        tick();
        chk("f_state_ret", state_out, 4);
        chk("f_ret5", return_amount, 5);
        tick();
        chk("f_state_idle", state_out, 0);

        // cancel during dispense is ignored, late coin refused, change 5
        coin(8'd30);
        sel(2'd2);
        tick();
        cancel = 1'b1;
        coin_valid = 1'b1;
        coin_value = 8'd5;
        tick();
        idle_inputs();
        chk("g_state_sel", state_out, 2);
        chk("g_motor", dispense_product, 1);
        chk("g_reject", coin_reject, 1);
        chk("g_bal30", balance, 30);
        tick();
        chk("g_motor_c4", dispense_product, 1);
        tick();
        chk("g_done", product_dispense_done, 1);
        chk("g_state_chg", state_out, 3);
        chk("g_bal5", balance, 5);
        tick();
        chk("g_chg_done", change_dispense_done, 1);
        chk("g_chg5", change_amount, 5);
        chk("g_state_idle", state_out, 0);

        // reset mid-dispense aborts with no done pulse
        coin(8'd20);
        sel(2'd1);
        tick();
        chk("h_motor_pre", dispense_product, 1);
        rst_n = 1'b0;
        #1;
        chk("h_motor_abort", dispense_product, 0);
        chk("h_state_rst", state_out, 0);
        chk("h_bal_lost", balance, 0);
        chk("h_pid_rst", product_id, 0);
        tick();
        chk("h_no_done", product_dispense_done, 0);
        rst_n = 1'b1;
        tick();
        chk("h_no_done_after", product_dispense_done, 0);
        chk("h_idle_after", state_out, 0);
        coin(8'd15);
        chk("h_recover_bal", balance, 15);
        chk("h_recover_state", state_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
